// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FSM encoding, vectors, NOP and IF_ID field layout.
package if_stage_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    HOLD,
    DROP
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;

  localparam logic [31:0] NOP = 32'b0;

  localparam int PC4_HI   = 63;
  localparam int PC4_LO   = 32;
  localparam int INSTR_HI = 31;
  localparam int INSTR_LO = 0;

  function automatic logic [63:0] pack_if_id(
    input logic [31:0] pc4,
    input logic [31:0] instr
  );
    return {pc4, instr};
  endfunction

endpackage

// File: rtl/if_stage_pc_select.sv
// Next-PC priority mux with redirect and interrupt-take decode.
// Interrupt path present only when IF_IRQ_EN is defined.
module pc_select
  import if_stage_pkg::*;
(
  input  logic        pc_msb,
  input  logic        if_id_valid,
  input  logic        if_interrupt,
  input  logic        pc_write,
  input  logic        id_exception,
  input  logic        z,
  input  logic        jr,
  input  logic        j,
  input  logic        irq,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  input  logic [31:0] jump_target,
  output logic        take,
  output logic        irq_take,
  output logic [31:0] target
);

  // stale operands while ID stalls, so only redirect on a live slot
  assign take = if_id_valid & pc_write
              & (id_exception | z | jr | j);

`ifdef IF_IRQ_EN
  // kernel mode masks irq; a redirect wins this cycle
  assign irq_take = irq & ~pc_msb & ~take
                  & pc_write & ~if_interrupt;
`else
  logic irq_unused;
  assign irq_take   = 1'b0;
  assign irq_unused = irq ^ pc_msb ^ if_interrupt;
`endif

  // exception > branch > jr > jump, interrupt vector overrides
  always_comb begin
    target = jump_target;
    if (id_exception)
      target = ILLOP_PC;
    else if (z)
      target = branch_target;
    else if (jr)
      target = jr_target;
`ifdef IF_IRQ_EN
    if (irq_take)
      target = XADR_PC;
`endif
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, IF_ID.
// Define IF_IRQ_EN to enable interrupt bubble injection.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic        PC_IF_ID_Write,
  input  logic        ID_exception,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [63:0] IF_ID,
  output logic        IF_ID_valid,
  output logic        IF_interrupt
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] hold_buf;
  logic [31:0] fetch_word;
  logic [31:0] target;
  logic        take;
  logic        irq_take;
  logic        ev;
  logic        fetch_write;

  pc_select u_sel (
    .pc_msb        (pc[31]),
    .if_id_valid   (IF_ID_valid),
    .if_interrupt  (IF_interrupt),
    .pc_write      (PC_IF_ID_Write),
    .id_exception  (ID_exception),
    .z             (Z),
    .jr            (JR),
    .j             (J),
    .irq           (irq),
    .branch_target (branch_target),
    .jr_target     (jr_target),
    .jump_target   (jump_target),
    .take          (take),
    .irq_take      (irq_take),
    .target        (target)
  );

  assign pc_plus4  = pc + 32'd4;
  assign ev        = take | irq_take;
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  assign fetch_word = (state == HOLD) ? hold_buf
                                      : imem_rdata;

  assign fetch_write = ~ev & PC_IF_ID_Write
    & (((state == WAIT) & imem_valid)
       | (state == HOLD));

  // fetch sequencing: one request in flight, park word on stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= BOOT;
      hold_buf <= NOP;
    end else begin
      unique case (state)
        BOOT: state <= REQ;
        REQ:  state <= ev ? DROP : WAIT;
        WAIT: begin
          if (imem_valid) begin
            if (ev || PC_IF_ID_Write) begin
              state <= REQ;
            end else begin
              hold_buf <= imem_rdata;
              state    <= HOLD;
            end
          end else if (ev) begin
            state <= DROP;
          end
        end
        HOLD: if (ev || PC_IF_ID_Write) state <= REQ;
        DROP: if (imem_valid) state <= REQ;
        default: state <= BOOT;
      endcase
    end
  end

  // PC and IF_ID: redirect/bubble beats a normal write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      IF_ID       <= '0;
      IF_ID_valid <= 1'b0;
    end else if (ev) begin
      pc          <= target;
      IF_ID_valid <= 1'b0;
      IF_ID       <= irq_take ? pack_if_id(pc_plus4, NOP)
                              : '0;
    end else if (fetch_write) begin
      pc          <= pc_plus4;
      IF_ID_valid <= 1'b1;
      IF_ID       <= pack_if_id(pc_plus4, fetch_word);
    end
  end

`ifdef IF_IRQ_EN
  // bubble tag, cleared by the next real IF_ID write
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      IF_interrupt <= 1'b0;
    else if (irq_take)
      IF_interrupt <= 1'b1;
    else if (fetch_write)
      IF_interrupt <= 1'b0;
  end
`else
  assign IF_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage.
// Behavioural fetch model predicts every cycle's outputs.
module tb_if_stage;

  localparam logic [31:0] R_PC = 32'h8000_0000;
  localparam logic [31:0] I_PC = 32'h8000_0004;
  localparam logic [31:0] X_PC = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        Z, J, JR;
  logic        PC_IF_ID_Write;
  logic        ID_exception;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic        irq;
  logic [63:0] IF_ID;
  logic        IF_ID_valid;
  logic        IF_interrupt;

  if_stage dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_valid     (imem_valid),
    .Z              (Z),
    .J              (J),
    .JR             (JR),
    .PC_IF_ID_Write (PC_IF_ID_Write),
    .ID_exception   (ID_exception),
    .branch_target  (branch_target),
    .jump_target    (jump_target),
    .jr_target      (jr_target),
    .irq            (irq),
    .IF_ID          (IF_ID),
    .IF_ID_valid    (IF_ID_valid),
    .IF_interrupt   (IF_interrupt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [63:0] ifid;
    logic        vld;
    logic        intr;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;

  // reference model: fetch bookkeeping as plain flags
  logic [31:0] m_pc;
  logic [63:0] m_ifid;
  logic        m_vld, m_intr;
  bit          m_boot, m_issue, m_out, m_disc, m_buf;
  logic [31:0] m_bufw;

  // memory responder
  bit          mem_pend;
  int          mem_lat;
  logic [31:0] mem_data;

  function automatic logic [31:0] word_of(
    input logic [31:0] a
  );
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] req
  );
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, req);
  endtask

  task automatic model_reset;
    m_pc   = R_PC;
    m_ifid = '0;
    m_vld  = 1'b0;
    m_intr = 1'b0;
    m_boot = 1;
    m_issue = 0;
    m_out  = 0;
    m_disc = 0;
    m_buf  = 0;
    m_bufw = '0;
  endtask

  task automatic push_exp;
    q.push_back('{m_issue, m_pc, m_ifid, m_vld, m_intr});
  endtask

  task automatic deliver(input logic [31:0] w);
    m_ifid = {m_pc + 32'd4, w};
    m_vld  = 1'b1;
    m_intr = 1'b0;
    m_pc   = m_pc + 32'd4;
  endtask

  task automatic model_step;
    logic        redir, itake, ev, wr, d;
    logic [31:0] tgt, old_pc;
    bit          nxt;
    wr    = PC_IF_ID_Write;
    redir = m_vld && wr
          && (ID_exception || Z || JR || J);
    if (ID_exception)  tgt = I_PC;
    else if (Z)        tgt = branch_target;
    else if (JR)       tgt = jr_target;
    else               tgt = jump_target;
    itake = 1'b0;
`ifdef IF_IRQ_EN
    itake = irq && !m_pc[31] && !redir
          && wr && !m_intr;
`endif
    ev     = redir || itake;
    old_pc = m_pc;
    nxt    = 0;
    if (m_boot) begin
      m_boot = 0;
      nxt    = 1;
    end else if (m_issue) begin
      m_out  = 1;
      m_disc = ev;
    end else if (m_out) begin
      if (imem_valid) begin
        d      = m_disc;
        m_disc = 0;
        m_out  = 0;
        if (d || ev) nxt = 1;
        else if (wr) begin
          deliver(imem_rdata);
          nxt = 1;
        end else begin
          m_buf  = 1;
          m_bufw = imem_rdata;
        end
      end else if (ev) begin
        m_disc = 1;
      end
    end else if (m_buf) begin
      if (ev) begin
        m_buf = 0;
        nxt   = 1;
      end else if (wr) begin
        deliver(m_bufw);
        m_buf = 0;
        nxt   = 1;
      end
    end
    if (ev) begin
      m_pc   = itake ? X_PC : tgt;
      m_vld  = 1'b0;
      m_ifid = itake ? {old_pc + 32'd4, 32'h0} : '0;
      if (itake) m_intr = 1'b1;
    end
    m_issue = nxt;
  endtask

  function automatic logic [31:0] rand_tgt;
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFFC;
    return {t[31:2], 2'b00};
  endfunction

  task automatic cycle(input bit quiet, input bit rst_now);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    if (mem_pend) begin
      if (mem_lat == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem_data;
        mem_pend   = 0;
      end else begin
        mem_lat--;
      end
    end
    if (imem_req) begin
      mem_pend = 1;
      mem_lat  = quiet ? 0 : $urandom_range(0, 2);
      mem_data = quiet ? imem_addr : word_of(imem_addr);
    end
    PC_IF_ID_Write = quiet || ($urandom_range(0, 99) < 75);
    Z            = !quiet && ($urandom_range(0, 99) < 12);
    J            = !quiet && ($urandom_range(0, 99) < 12);
    JR           = !quiet && ($urandom_range(0, 99) < 12);
    ID_exception = !quiet && ($urandom_range(0, 99) < 6);
    irq          = !quiet && ($urandom_range(0, 99) < 30);
    branch_target = rand_tgt();
    jump_target   = rand_tgt();
    jr_target     = rand_tgt();
    model_step();
    @(posedge clk);
    #1;
    if (rst_now) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
      model_reset();
      if (mem_pend) mem_lat = 0;
    end
    push_exp();
  endtask

  // monitor: compare DUT outputs against queued predictions
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("imem_req", 64'(imem_req), 64'(e.req));
        if (e.req)
          check("imem_addr", 64'(imem_addr), 64'(e.addr));
        check("IF_ID", IF_ID, e.ifid);
        check("IF_ID_valid", 64'(IF_ID_valid), 64'(e.vld));
        check("IF_interrupt", 64'(IF_interrupt),
              64'(e.intr));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    imem_valid     = 1'b0;
    imem_rdata     = '0;
    Z              = 1'b0;
    J              = 1'b0;
    JR             = 1'b0;
    ID_exception   = 1'b0;
    PC_IF_ID_Write = 1'b1;
    irq            = 1'b0;
    branch_target  = '0;
    jump_target    = '0;
    jr_target      = '0;
    mem_pend       = 0;
    mem_lat        = 0;
    mem_data       = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    push_exp();
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 4000; i++)
      cycle(1'b0, i == 2000);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, issues single-outstanding fetches to the instruction memory, and registers {PC+4, instruction} into IF_ID, which ID consumes. It applies ID's redirect, stall and exception signals, and injects interrupt bubbles tagged for ID's register-file k0 save.

Parameters:
RESET_PC, 32'h8000_0000, PC after reset (kernel mode, bit 31 = 1)
ILLOP_PC, 32'h8000_0004, vector for an undefined instruction
XADR_PC, 32'h8000_0008, vector for an interrupt

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
imem_req  out  1  one-cycle fetch request pulse
imem_addr  out  32  fetch address; equals PC whenever imem_req=1
imem_rdata  in  32  fetched instruction; valid only with imem_valid
imem_valid  in  1  fetch response; at least 1 cycle after imem_req
Z  in  1  branch taken (from ID)
J  in  1  jump (from ID)
JR  in  1  jump register (from ID)
PC_IF_ID_Write  in  1  0 = ID stalled by hazard; hold PC and IF_ID
ID_exception  in  1  undefined instruction decoded in ID
branch_target  in  32  branch target
jump_target  in  32  jump target
jr_target  in  32  jump-register target
irq  in  1  external interrupt request, level-sensitive
IF_ID  out  64  {PC_plus4[63:32], instruction[31:0]}
IF_ID_valid  out  1  IF_ID holds a real fetched instruction
IF_interrupt  out  1  IF_ID holds an interrupt bubble (drives ID interrupt)

Behaviour:
- Reset values: PC=RESET_PC, IF_ID=64'b0 (NOP), IF_ID_valid=0, IF_interrupt=0, state=BOOT, imem_req=0.
- FSM states and transitions:
  - BOOT: one idle cycle, then REQ.
  - REQ: imem_req=1, imem_addr=PC; next state WAIT.
  - WAIT: wait for imem_valid.
    - imem_valid with PC_IF_ID_Write=1: write IF_ID={PC+4, imem_rdata}, IF_ID_valid=1, PC<=PC+4, next REQ.
    - imem_valid with PC_IF_ID_Write=0: capture imem_rdata into the hold buffer, next HOLD.
  - HOLD: when PC_IF_ID_Write=1, write the buffer to IF_ID, PC<=PC+4, next REQ.
  - DROP: a response is still outstanding but must be discarded; on imem_valid, next REQ.
- Throughput: 1 instruction per 2 cycles when memory answers in 1 cycle. PC+4 wraps mod 2^32.
- Redirect (take) = IF_ID_valid & PC_IF_ID_Write & (ID_exception|Z|JR|J).
  - Redirects are ignored while ID is stalled, because ID operands are stale.
  - Target priority: ID_exception→ILLOP_PC > Z→branch_target > JR→jr_target > J→jump_target.
- On a redirect:
  - PC<=target; IF_ID<=0, IF_ID_valid<=0.
  - State mapping: REQ→DROP, WAIT (no valid)→DROP, WAIT with imem_valid the same cycle→REQ (response discarded), HOLD→REQ (buffer discarded), DROP→DROP.
- Interrupt (see Optional Feature):
  - Taken when irq=1, PC[31]=0, no redirect this cycle, PC_IF_ID_Write=1, IF_interrupt=0.
  - On take: IF_ID<={PC+4, 32'b0}, IF_interrupt<=1, IF_ID_valid<=0, PC<=XADR_PC.
  - State mapping is the same as for a redirect. ID saves PC_plus4-4 (the interrupted PC) to k0.
  - IF_interrupt clears on the next IF_ID write. PC[31]=1 masks irq, so there is no nested interrupt.
- Simultaneous events: a redirect beats irq; irq retries next cycle if still asserted and PC[31]=0.
- Stall with no pending response: PC, IF_ID, IF_ID_valid and IF_interrupt all hold.
- Reset mid-fetch: state returns to BOOT. A late imem_valid arriving in BOOT or REQ is ignored.

Optional Feature:
IF_IRQ_EN
- Defined: interrupt injection as specified above.
- Undefined: irq is ignored, IF_interrupt is tied to 0, and XADR logic is removed.

Decomposition:
- Shared package holds:
  - State encoding: BOOT, REQ, WAIT, HOLD, DROP.
  - Vector constants: RESET_PC, ILLOP_PC, XADR_PC.
  - NOP constant: 32'b0.
  - IF_ID field offsets: PC_plus4 [63:32], instruction [31:0].
- One natural sub-module: pc_select (combinational next-PC priority mux plus the redirect and irq-take decode). The FSM, hold buffer and IF_ID register stay in if_stage.

Test Plan:
- Reset release, imem_valid 1 cycle after each req with rdata=addr: imem_addr 80000000, 80000004, ... every 2 cycles; IF_ID={80000004, 80000000} and onward.
- Stall: PC_IF_ID_Write=0 for 3 cycles while WAIT gets imem_valid: IF_ID unchanged, no new imem_req; buffered word appears the cycle after the stall drops.
- Branch Z=1, branch_target=80000100, asserted while WAIT: IF_ID_valid=0, late response discarded, next imem_addr=80000100.
- Z=1 with PC_IF_ID_Write=0: no redirect; PC unchanged.
- ID_exception=1 and J=1 together: next fetch at 80000004.
- IF_IRQ_EN, PC=00000040 in user mode, irq=1: IF_ID={00000044, 0}, IF_interrupt=1, next fetch 80000008; irq held afterwards causes no second injection while PC[31]=1.
